// File: rtl/fgba_bus_pkg.sv
// Shared definitions for the fgba memory-bus arbiter: width codes, arbiter
// state encoding and a counter-width helper.
package fgba_bus_pkg;

    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

    // Bits needed to hold 0..max_val; never less than one bit so a zero
    // parameter (e.g. timeout disabled) still yields a legal vector.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select for the two-master arbiter.
// Round-robin hands contention to the master that did not own the bus last;
// fixed priority favours m0 until m1 has lost STARVE_LIMIT times in a row.
module arb_pick
    import fgba_bus_pkg::*;
#(
    parameter bit ROUND_ROBIN  = 1'b1,
    parameter int STARVE_LIMIT = 4,
    parameter int SW           = cnt_width(STARVE_LIMIT)
) (
    input  logic          i_req0,
    input  logic          i_req1,
    input  logic          i_owner,
    input  logic [SW-1:0] i_starve_cnt,
    output logic          o_valid,
    output logic          o_winner
);

    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    // Pick a winner whenever at least one master is requesting.
    always_comb begin
        o_valid  = i_req0 | i_req1;
        o_winner = i_req1;
        if (i_req0 && i_req1) begin
            if (ROUND_ROBIN) begin
                o_winner = ~i_owner;
            end else begin
                o_winner = (i_starve_cnt == STARVE_MAX);
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single CPU-side memory port between m0 (cpu_armv4t) and m1
// (DMA/sound fetch). One whole transaction is granted at a time; a
// transaction memory never acknowledges is closed with an error pulse.
// Completion (ok/err) is combinational from mem_ok so the owner sees it in
// the same cycle memory does.
module mem_bus_arbiter
    import fgba_bus_pkg::*;
#(
    parameter bit ROUND_ROBIN  = 1'b1,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [1:0]  m0_width,
    input  logic        m0_read,
    input  logic        m0_write,
    output logic [31:0] m0_rdata,
    output logic        m0_ok,
    output logic        m0_err,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [1:0]  m1_width,
    input  logic        m1_read,
    input  logic        m1_write,
    output logic [31:0] m1_rdata,
    output logic        m1_ok,
    output logic        m1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_width,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ok,
    output logic        owner
);

    localparam int SW = cnt_width(STARVE_LIMIT);
    localparam int TW = cnt_width(TIMEOUT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit            TMO_EN     = (TIMEOUT > 0);

    arb_state_e    r_state;
    logic          r_owner;
    logic [SW-1:0] r_starve_cnt;
    logic [TW-1:0] r_tmo_cnt;

    logic w_req0;
    logic w_req1;
    logic w_pick_valid;
    logic w_winner;
    logic w_busy;
    logic w_own_read;
    logic w_own_write;
    logic w_abandon;
    logic w_done;
    logic w_timeout;
    logic w_finish;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    arb_pick #(
        .ROUND_ROBIN (ROUND_ROBIN),
        .STARVE_LIMIT(STARVE_LIMIT),
        .SW          (SW)
    ) u_arb_pick (
        .i_req0      (w_req0),
        .i_req1      (w_req1),
        .i_owner     (r_owner),
        .i_starve_cnt(r_starve_cnt),
        .o_valid     (w_pick_valid),
        .o_winner    (w_winner)
    );

    assign w_busy      = (r_state == ARB_BUSY);
    assign w_own_read  = r_owner ? m1_read  : m0_read;
    assign w_own_write = r_owner ? m1_write : m0_write;

    // Abandon wins over everything: a master that let go gets no ok.
    assign w_abandon = w_busy & ~w_own_read & ~w_own_write;
    assign w_done    = w_busy & ~w_abandon & mem_ok;
    assign w_timeout = w_busy & ~w_abandon & ~mem_ok & TMO_EN & (r_tmo_cnt == TMO_LAST);
    assign w_finish  = w_abandon | w_done | w_timeout;

    // A simultaneous read+write is treated as a write; the read is masked.
    assign mem_write = w_busy & w_own_write & ~w_timeout;
    assign mem_read  = w_busy & w_own_read & ~w_own_write & ~w_timeout;

    assign mem_addr  = r_owner ? m1_addr  : m0_addr;
    assign mem_wdata = r_owner ? m1_wdata : m0_wdata;
    assign mem_width = r_owner ? m1_width : m0_width;
    assign owner     = r_owner;

    assign m0_ok    = (w_done | w_timeout) & ~r_owner;
    assign m1_ok    = (w_done | w_timeout) &  r_owner;
    assign m0_err   = w_timeout & ~r_owner;
    assign m1_err   = w_timeout &  r_owner;
    assign m0_rdata = (w_timeout & ~r_owner) ? '0 : mem_rdata;
    assign m1_rdata = (w_timeout &  r_owner) ? '0 : mem_rdata;

    // Arbiter FSM with ownership, starvation and timeout counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ARB_IDLE;
            r_owner      <= 1'b1;
            r_starve_cnt <= '0;
            r_tmo_cnt    <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_valid) begin
                        r_owner   <= w_winner;
                        r_state   <= ARB_BUSY;
                        r_tmo_cnt <= '0;
                        if (w_winner) begin
                            r_starve_cnt <= '0;
                        end else if (w_req1 && (r_starve_cnt != STARVE_MAX)) begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end
                end
                ARB_BUSY: begin
                    if (w_finish) begin
                        r_state <= ARB_RELEASE;
                    end else if (r_tmo_cnt != TMO_MAX) begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                ARB_RELEASE: begin
                    r_state <= ARB_IDLE;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
